// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL (shift-add) / DIVU (restoring) sequencer that borrows the shared 16-bit ALU.
// Latency: fixed 32 cycles from start edge to o_done; divide-by-zero completes on the start edge.
// Backpressure: o_busy stalls the core while the sequencer owns the ALU; i_start is ignored unless idle.
module alu_muldiv_sequencer #(
    parameter logic [3:0] OP_ADD     = 4'h0,
    parameter logic [3:0] OP_SUB     = 4'h1,
    parameter logic [3:0] OP_SHIFT   = 4'h5,
    parameter logic       SHIFT_LEFT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_op,
    input  logic [15:0] i_operand_a,
    input  logic [15:0] i_operand_b,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_result_lo,
    output logic [15:0] o_result_hi,
    input  logic [3:0]  i_core_opcode,
    input  logic        i_core_shift_dir,
    input  logic [15:0] i_core_data1,
    input  logic [15:0] i_core_data2,
    output logic [3:0]  o_alu_opcode,
    output logic        o_alu_shift_dir,
    output logic [15:0] o_alu_data1,
    output logic [15:0] o_alu_data2,
    input  logic [15:0] i_alu_result
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_ADD = 3'd1,
        MUL_SHL = 3'd2,
        DIV_SHL = 3'd3,
        DIV_SUB = 3'd4
    } state_t;

    state_t      state, state_nxt;
    // a doubles as the dividend/quotient register, acc as the remainder, b as the divisor
    logic [15:0] a, a_nxt, b, b_nxt, acc, acc_nxt;
    logic        carry, carry_nxt;
    logic [4:0]  count, count_nxt;
    logic        done_nxt, err_nxt;
    logic [15:0] lo_nxt, hi_nxt;

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            count       <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_result_lo <= '0;
            o_result_hi <= '0;
        end else begin
            state       <= state_nxt;
            a           <= a_nxt;
            b           <= b_nxt;
            acc         <= acc_nxt;
            carry       <= carry_nxt;
            count       <= count_nxt;
            o_done      <= done_nxt;
            o_err       <= err_nxt;
            o_result_lo <= lo_nxt;
            o_result_hi <= hi_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        a_nxt           = a;
        b_nxt           = b;
        acc_nxt         = acc;
        carry_nxt       = carry;
        count_nxt       = count;
        done_nxt        = 1'b0;
        err_nxt         = o_err;
        lo_nxt          = o_result_lo;
        hi_nxt          = o_result_hi;
        o_alu_opcode    = i_core_opcode;
        o_alu_shift_dir = i_core_shift_dir;
        o_alu_data1     = i_core_data1;
        o_alu_data2     = i_core_data2;

        case (state)
            IDLE: begin
                if (i_start) begin
                    a_nxt     = i_operand_a;
                    b_nxt     = i_operand_b;
                    acc_nxt   = '0;
                    carry_nxt = 1'b0;
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                    if (!i_op) begin
                        state_nxt = MUL_ADD;
                    end else if (i_operand_b != 16'd0) begin
                        state_nxt = DIV_SHL;
                    end else begin
                        lo_nxt   = 16'hFFFF;
                        hi_nxt   = i_operand_a;
                        err_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end
                end
            end
            MUL_ADD: begin
                o_alu_opcode    = OP_ADD;
                o_alu_shift_dir = SHIFT_LEFT;
                o_alu_data1     = acc;
                o_alu_data2     = b[0] ? a : 16'd0;
                acc_nxt         = i_alu_result;
                state_nxt       = MUL_SHL;
            end
            MUL_SHL: begin
                o_alu_opcode    = OP_SHIFT;
                o_alu_shift_dir = SHIFT_LEFT;
                o_alu_data1     = a;
                o_alu_data2     = 16'd1;
                a_nxt           = i_alu_result;
                b_nxt           = b >> 1;
                if (count == 5'd15) begin
                    lo_nxt    = acc;
                    hi_nxt    = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + 5'd1;
                    state_nxt = MUL_ADD;
                end
            end
            DIV_SHL: begin
                o_alu_opcode    = OP_SHIFT;
                o_alu_shift_dir = SHIFT_LEFT;
                o_alu_data1     = acc;
                o_alu_data2     = 16'd1;
                acc_nxt         = i_alu_result | {15'd0, a[15]};
                carry_nxt       = acc[15];
                a_nxt           = a << 1;
                state_nxt       = DIV_SUB;
            end
            DIV_SUB: begin
                o_alu_opcode    = OP_SUB;
                o_alu_shift_dir = SHIFT_LEFT;
                o_alu_data1     = acc;
                o_alu_data2     = b;
                // carry holds the 17th remainder bit lost by the shift
                if (carry || (acc >= b)) begin
                    acc_nxt = i_alu_result;
                    a_nxt   = {a[15:1], 1'b1};
                end
                if (count == 5'd15) begin
                    lo_nxt    = a_nxt;
                    hi_nxt    = acc_nxt;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + 5'd1;
                    state_nxt = DIV_SHL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed-vector bench for alu_muldiv_sequencer with a behavioural ALU model on the mux outputs.
module tb_alu_muldiv_sequencer;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_SHIFT = 4'h5;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_op = 1'b0;
    logic [15:0] i_operand_a = '0;
    logic [15:0] i_operand_b = '0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_result_lo, o_result_hi;
    logic [3:0]  i_core_opcode = '0;
    logic        i_core_shift_dir = 1'b0;
    logic [15:0] i_core_data1 = '0;
    logic [15:0] i_core_data2 = '0;
    logic [3:0]  o_alu_opcode;
    logic        o_alu_shift_dir;
    logic [15:0] o_alu_data1, o_alu_data2;
    logic [15:0] i_alu_result;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    alu_muldiv_sequencer dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_op(i_op),
        .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_result_lo(o_result_lo), .o_result_hi(o_result_hi),
        .i_core_opcode(i_core_opcode), .i_core_shift_dir(i_core_shift_dir),
        .i_core_data1(i_core_data1), .i_core_data2(i_core_data2),
        .o_alu_opcode(o_alu_opcode), .o_alu_shift_dir(o_alu_shift_dir),
        .o_alu_data1(o_alu_data1), .o_alu_data2(o_alu_data2),
        .i_alu_result(i_alu_result)
    );

    always_comb begin
        i_alu_result = '0;
        case (o_alu_opcode)
            OP_ADD:   i_alu_result = o_alu_data1 + o_alu_data2;
            OP_SUB:   i_alu_result = o_alu_data1 - o_alu_data2;
            OP_SHIFT: i_alu_result = o_alu_shift_dir ? (o_alu_data1 << o_alu_data2[3:0])
                                                     : (o_alu_data1 >> o_alu_data2[3:0]);
            default:  i_alu_result = '0;
        endcase
    end

    typedef struct {
        string       name;
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        bit busy_ok;
        @(negedge i_clk);
        i_op = v.op;
        i_operand_a = v.a;
        i_operand_b = v.b;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        if (v.op && v.b == 16'd0) begin
            chk({v.name, " done@N"}, {31'd0, o_done}, 32'd1);
            chk({v.name, " busy@N"}, {31'd0, o_busy}, 32'd0);
        end else begin
            n = 0;
            busy_ok = 1'b1;
            while (!o_done && n < 100) begin
                if (!o_busy) busy_ok = 1'b0;
                @(posedge i_clk);
                #1;
                n++;
            end
            chk({v.name, " latency"}, n, 32'd32);
            chk({v.name, " busy held"}, {31'd0, busy_ok}, 32'd1);
            chk({v.name, " busy end"}, {31'd0, o_busy}, 32'd0);
        end
        chk({v.name, " lo"}, {16'd0, o_result_lo}, {16'd0, v.exp_lo});
        chk({v.name, " hi"}, {16'd0, o_result_hi}, {16'd0, v.exp_hi});
        chk({v.name, " err"}, {31'd0, o_err}, {31'd0, v.exp_err});
        @(posedge i_clk);
        #1;
        chk({v.name, " done pulse"}, {31'd0, o_done}, 32'd0);
        chk({v.name, " lo hold"}, {16'd0, o_result_lo}, {16'd0, v.exp_lo});
    endtask

    initial begin
        int dones;
        vecs.push_back('{"mul3x5",       1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0});
        vecs.push_back('{"mul_wrap",     1'b0, 16'h1234, 16'h0100, 16'h3400, 16'h0000, 1'b0});
        vecs.push_back('{"mul_ffff",     1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
        vecs.push_back('{"mul_zero",     1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{"div100_7",     1'b1, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0});
        vecs.push_back('{"div_carry",    1'b1, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0});
        vecs.push_back('{"div_by_zero",  1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1});
        vecs.push_back('{"div_small",    1'b1, 16'd5,    16'd9,    16'h0000, 16'h0005, 1'b0});
        vecs.push_back('{"div8000_1",    1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0});

        #1;
        chk("reset busy", {31'd0, o_busy}, 32'd0);
        chk("reset done", {31'd0, o_done}, 32'd0);
        chk("reset err", {31'd0, o_err}, 32'd0);
        chk("reset result", {o_result_hi, o_result_lo}, 32'd0);
        #12;
        i_reset_n = 1'b1;

        // idle passthrough
        @(negedge i_clk);
        i_core_opcode = OP_SUB;
        i_core_shift_dir = 1'b1;
        i_core_data1 = 16'd9;
        i_core_data2 = 16'd4;
        #1;
        chk("pass opcode", {28'd0, o_alu_opcode}, {28'd0, OP_SUB});
        chk("pass dir", {31'd0, o_alu_shift_dir}, 32'd1);
        chk("pass data1", {16'd0, o_alu_data1}, 32'd9);
        chk("pass data2", {16'd0, o_alu_data2}, 32'd4);
        chk("pass busy", {31'd0, o_busy}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // sequencer takes the ALU away from the core while busy
        i_core_opcode = 4'hF;
        @(negedge i_clk);
        i_op = 1'b0;
        i_operand_a = 16'h1234;
        i_operand_b = 16'h0100;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        chk("busy owns alu", {28'd0, o_alu_opcode}, {28'd0, OP_ADD});
        repeat (5) @(negedge i_clk);
        i_operand_a = 16'd9;
        i_operand_b = 16'd9;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        dones = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done) dones++;
        end
        chk("restart ignored dones", dones, 32'd1);
        chk("restart ignored lo", {16'd0, o_result_lo}, 32'h3400);

        // reset mid-multiply
        @(negedge i_clk);
        i_operand_a = 16'd3;
        i_operand_b = 16'd5;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (20) @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        chk("midreset busy", {31'd0, o_busy}, 32'd0);
        chk("midreset done", {31'd0, o_done}, 32'd0);
        chk("midreset err", {31'd0, o_err}, 32'd0);
        chk("midreset result", {o_result_hi, o_result_lo}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) dones++;
        end
        chk("midreset no done", dones, 32'd0);
        run_op('{"mul7x6", 1'b0, 16'd7, 16'd6, 16'h002A, 16'h0000, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
